rx_deserializer: RTL and testbench

RX_DESERIALIZER -- requirements
Module: rx_deserializer

---
 rtl/rx_pkg.sv | 12 +
 rtl/flex_stp_sr.sv | 40 ++++
 rtl/rx_deserializer.sv | 138 +++++++++++++
 tb/tb_rx_deserializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive path.
package rx_pkg;

    localparam int unsigned RX_DEFAULT_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/flex_stp_sr.sv
// Serial-to-parallel shift register with selectable shift direction.
module flex_stp_sr
    import rx_pkg::*;
#(
    parameter int unsigned NUM_BITS  = RX_DEFAULT_BITS,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] sr_d;
    logic [NUM_BITS-1:0] sr_q;

    // MSB-first fills from bit 0 upward; LSB-first fills from the top downward.
    always_comb begin
        sr_d = sr_q;
        if (shift_enable) begin
            if (SHIFT_MSB) begin
                sr_d = {sr_q[NUM_BITS-2:0], serial_in};
            end else begin
                sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign parallel_out = sr_q;

endmodule

// File: rtl/rx_deserializer.sv
// Receives framed serial words clocked by an asynchronous sclk and hands them
// to a clk-domain consumer through a ready/acknowledge buffer.
module rx_deserializer
    import rx_pkg::*;
#(
    parameter int unsigned NUM_BITS  = RX_DEFAULT_BITS,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                sclk,
    input  logic                ss_n,
    input  logic                serial_in,
    input  logic                data_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                rising_edge_found
);

    localparam int unsigned CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    logic                sclk_s1_d, sclk_s1_q, sclk_s2_d, sclk_s2_q;
    logic                sclk_prev_d, sclk_prev_q;
    logic                ss_s1_d, ss_s1_q, ss_s2_d, ss_s2_q;
    logic                sin_s1_d, sin_s1_q, sin_s2_d, sin_s2_q;
    logic                edge_d, edge_q;
    rx_state_t           state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [NUM_BITS-1:0] rx_data_d, rx_data_q;
    logic                ready_d, ready_q;
    logic                ovr_d, ovr_q;

    logic                shift_en;
    logic                last_bit;
    logic [NUM_BITS-1:0] word;

    flex_stp_sr #(
        .NUM_BITS (NUM_BITS),
        .SHIFT_MSB(SHIFT_MSB)
    ) u_sr (
        .clk         (clk),
        .n_rst       (n_rst),
        .shift_enable(shift_en),
        .serial_in   (sin_s2_q),
        .parallel_out(word)
    );

    always_comb begin
        sclk_s1_d   = sclk;
        sclk_s2_d   = sclk_s1_q;
        sclk_prev_d = sclk_s2_q;
        ss_s1_d     = ss_n;
        ss_s2_d     = ss_s1_q;
        sin_s1_d    = serial_in;
        sin_s2_d    = sin_s1_q;
        edge_d      = sclk_s2_q & ~sclk_prev_q;

        shift_en = edge_q & ~ss_s2_q;
        last_bit = (cnt_q == CNT_W'(NUM_BITS - 1));

        cnt_d = cnt_q;
        if (ss_s2_q) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = last_bit ? '0 : cnt_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (!ss_s2_q) state_d = SHIFT;
            SHIFT: begin
                if (ss_s2_q) begin
                    state_d = IDLE;
                end else if (shift_en && last_bit) begin
                    state_d = LOAD;
                end
            end
            LOAD:    state_d = ss_s2_q ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase

        // Acknowledge clears first; a LOAD in the same cycle then re-arms ready.
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;
        if (ready_q && data_read) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (state_q == LOAD) begin
            if (!ready_q || data_read) begin
                rx_data_d = word;
                ready_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
            sin_s1_q    <= 1'b1;
            sin_s2_q    <= 1'b1;
            edge_q      <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_data_q   <= '1;
            ready_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_prev_q <= sclk_prev_d;
            ss_s1_q     <= ss_s1_d;
            ss_s2_q     <= ss_s2_d;
            sin_s1_q    <= sin_s1_d;
            sin_s2_q    <= sin_s2_d;
            edge_q      <= edge_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            ready_q     <= ready_d;
            ovr_q       <= ovr_d;
        end
    end

    assign rx_data           = rx_data_q;
    assign data_ready        = ready_q;
    assign overrun_error     = ovr_q;
    assign rising_edge_found = edge_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer: MSB-first and LSB-first instances share stimulus.
module tb_rx_deserializer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       sclk;
    logic       ss_n;
    logic       serial_in;
    logic       data_read;

    logic [7:0] rx_data,   rx_data_l;
    logic       data_ready, data_ready_l;
    logic       overrun_error, overrun_error_l;
    logic       rising_edge_found, rising_edge_found_l;

    int total = 0;
    int bad   = 0;
    int re_cnt = 0;

    always #5 clk = ~clk;

    rx_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (
        .clk(clk), .n_rst(n_rst), .sclk(sclk), .ss_n(ss_n), .serial_in(serial_in),
        .data_read(data_read), .rx_data(rx_data), .data_ready(data_ready),
        .overrun_error(overrun_error), .rising_edge_found(rising_edge_found)
    );

    rx_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (
        .clk(clk), .n_rst(n_rst), .sclk(sclk), .ss_n(ss_n), .serial_in(serial_in),
        .data_read(data_read), .rx_data(rx_data_l), .data_ready(data_ready_l),
        .overrun_error(overrun_error_l), .rising_edge_found(rising_edge_found_l)
    );

    always @(negedge clk) begin
        if (rising_edge_found) re_cnt++;
    end

    typedef struct {
        logic [7:0] word;
        bit         rd_first;
        logic [7:0] exp_data;
        bit         exp_rdy;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        tick(1);
        data_read = 1'b0;
        tick(1);
    endtask

    // Bits go out MSB of w first; early_ss raises ss_n so it lands in the LOAD cycle.
    task automatic send_frame(input logic [7:0] w, input int unsigned nbits,
                              input bit early_ss, input bit close);
        tick(1);
        ss_n = 1'b0;
        tick(4);
        for (int unsigned i = 0; i < nbits; i++) begin
            serial_in = w[7-i];
            tick(4);
            sclk = 1'b1;
            if (early_ss && (i == nbits - 1)) begin
                tick(2);
                ss_n = 1'b1;
                tick(2);
            end else begin
                tick(4);
            end
            sclk = 1'b0;
        end
        if (close) begin
            tick(4);
            ss_n = 1'b1;
            tick(8);
        end
    endtask

    task automatic wait_edges(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (re_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int base;
        bit ok;

        vecs[0] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{8'hC3, 1'b0, 8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 8'h00, 1'b1, 1'b1};

        n_rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; serial_in = 1'b1; data_read = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_rx", rx_data, 8'hFF);
        chk("rst_ready", data_ready, 0);
        chk("rst_ovr", overrun_error, 0);
        chk("rst_edge", rising_edge_found, 0);
        chk("rst_rx_l", rx_data_l, 8'hFF);
        chk("rst_ready_l", data_ready_l, 0);
        chk("rst_ovr_l", overrun_error_l, 0);
        chk("rst_edge_l", rising_edge_found_l, 0);
        tick(2);
        n_rst = 1'b1;
        tick(4);

        // Bits 1,0,0,0,0,0,0,0: MSB-first sees 0x80, LSB-first sees 0x01.
        send_frame(8'h80, 8, 1'b0, 1'b1);
        chk("msbf_rx", rx_data, 8'h80);
        chk("lsbf_rx", rx_data_l, 8'h01);
        chk("lsbf_ready", data_ready_l, 1);
        pulse_read();
        chk("clr_ready", data_ready, 0);

        // 0xA5 with edge count and load latency.
        base = re_cnt;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b1);
            begin
                wait_edges(base + 8, ok);
                chk("a5_edge_timeout", ok, 1);
                @(negedge clk);
                chk("a5_ready_early", data_ready, 0);
                @(negedge clk);
                chk("a5_ready", data_ready, 1);
                chk("a5_data", rx_data, 8'hA5);
            end
        join
        chk("a5_edges", re_cnt - base, 8);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].rd_first) pulse_read();
            base = re_cnt;
            send_frame(vecs[i].word, 8, 1'b0, 1'b1);
            chk($sformatf("vec%0d_edges", i), re_cnt - base, 8);
            chk($sformatf("vec%0d_rx", i), rx_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_ready", i), data_ready, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_ovr", i), overrun_error, vecs[i].exp_ovr);
        end

        pulse_read();
        chk("ack_ready", data_ready, 0);
        chk("ack_ovr", overrun_error, 0);
        chk("ack_rx", rx_data, 8'h00);
        pulse_read();
        chk("idle_ack_ready", data_ready, 0);
        chk("idle_ack_rx", rx_data, 8'h00);

        // Overrun cleared by an acknowledge that coincides with the next LOAD.
        send_frame(8'h11, 8, 1'b0, 1'b1);
        chk("b2b_11", rx_data, 8'h11);
        send_frame(8'h33, 8, 1'b0, 1'b1);
        chk("b2b_33_rx", rx_data, 8'h11);
        chk("b2b_33_ovr", overrun_error, 1);
        base = re_cnt;
        fork
            send_frame(8'h22, 8, 1'b0, 1'b1);
            begin
                wait_edges(base + 8, ok);
                chk("b2b_edge_timeout", ok, 1);
                @(posedge clk);
                #1 data_read = 1'b1;
                @(posedge clk);
                #1 data_read = 1'b0;
            end
        join
        chk("b2b_22_rx", rx_data, 8'h22);
        chk("b2b_22_ready", data_ready, 1);
        chk("b2b_22_ovr", overrun_error, 0);

        // ss_n rises during the LOAD cycle; the word must still land.
        pulse_read();
        send_frame(8'h96, 8, 1'b1, 1'b1);
        chk("ssload_rx", rx_data, 8'h96);
        chk("ssload_ready", data_ready, 1);

        // Aborted partial frame must not leak into the next one.
        pulse_read();
        send_frame(8'hFF, 5, 1'b0, 1'b1);
        chk("partial_ready", data_ready, 0);
        send_frame(8'h5A, 8, 1'b0, 1'b1);
        chk("partial_rx", rx_data, 8'h5A);
        chk("partial_ready2", data_ready, 1);

        // Reset mid-word.
        send_frame(8'hF0, 4, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        chk("midrst_rx", rx_data, 8'hFF);
        chk("midrst_ready", data_ready, 0);
        chk("midrst_ovr", overrun_error, 0);
        chk("midrst_edge", rising_edge_found, 0);
        ss_n = 1'b1;
        tick(3);
        n_rst = 1'b1;
        tick(4);
        send_frame(8'hF0, 8, 1'b0, 1'b1);
        chk("postrst_rx", rx_data, 8'hF0);
        chk("postrst_ready", data_ready, 1);
        chk("postrst_ovr", overrun_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
